// File: rtl/debounce_pkg.sv
// Shared types and helpers for the switch debouncer bank.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DLY1 = 2'b01,
        HALT = 2'b10,
        DLY2 = 2'b11
    } db_state_e;

    function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch: synchroniser, window counter, 4-state FSM, strobes.
// Long-press strobe is built only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DB_CYC   = 8,
    parameter int unsigned LONG_CYC = 20
) (
    input  logic clk_50MHz_i,
    input  logic rst_async_la_i,
    input  logic sw_noisy_i,
    output logic sw_clean_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned CNT_W = $clog2(LONG_CYC);
`else
    localparam int unsigned CNT_W = $clog2(DB_CYC);
`endif
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);

    if (DB_CYC < 2) begin : g_bad_db
        $error("debounce_channel: DB_CYC must be >= 2");
    end
    if (LONG_CYC <= DB_CYC) begin : g_bad_long
        $error("debounce_channel: LONG_CYC must exceed DB_CYC");
    end

    logic [1:0]       sync_q, sync_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;

    assign s = sync_q[1];

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    logic long_q, long_d;
    logic long_done_q, long_done_d;
`endif

    always_comb begin
        sync_d    = {sync_q[0], sw_noisy_i};
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: if (s) state_d = DLY1;
            DLY1: begin
                if (!s) state_d = IDLE;
                else if (cnt_q == DB_LAST) begin
                    state_d = HALT;
                    press_d = 1'b1;
                end
            end
            HALT: if (!s) state_d = DLY2;
            DLY2: begin
                if (s) state_d = HALT;
                else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (state_q == DLY1 || state_q == DLY2) cnt_d = cnt_q + 1'b1;
`ifdef DEBOUNCE_LONG_PRESS_EN
        else if (state_q == HALT && cnt_q != LONG_LAST) cnt_d = cnt_q + 1'b1;

        // long_done survives DLY2 bounces so a single press strobes at most once
        long_d      = 1'b0;
        long_done_d = long_done_q;
        if (state_q == IDLE) long_done_d = 1'b0;
        else if (state_q == HALT && state_d == HALT && cnt_q == LONG_LAST && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef DEBOUNCE_LONG_PRESS_EN
            long_q      <= 1'b0;
            long_done_q <= 1'b0;
`endif
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef DEBOUNCE_LONG_PRESS_EN
            long_q      <= long_d;
            long_done_q <= long_done_d;
`endif
        end
    end

    assign sw_clean_o = (state_q == HALT) || (state_q == DLY2);
    assign press_o    = press_q;
    assign release_o  = release_q;
`ifdef DEBOUNCE_LONG_PRESS_EN
    assign long_o     = long_q;
`else
    assign long_o     = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent switch debouncers in the clk_50MHz_i domain.
// Define DEBOUNCE_LONG_PRESS_EN to enable the long-press strobe.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned DB_MS   = 30,
    parameter int unsigned LONG_MS = 1000
) (
    input  logic            clk_50MHz_i,
    input  logic            rst_async_la_i,
    input  logic [N_CH-1:0] sw_noisy_i,
    output logic [N_CH-1:0] sw_clean_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o
);

    localparam int unsigned DB_CYC   = ms_to_cyc(CLK_HZ, DB_MS);
    localparam int unsigned LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
        $error("debounce_bank: N_CH must be 1..32");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DB_CYC   (DB_CYC),
            .LONG_CYC (LONG_CYC)
        ) u_ch (
            .clk_50MHz_i    (clk_50MHz_i),
            .rst_async_la_i (rst_async_la_i),
            .sw_noisy_i     (sw_noisy_i[i]),
            .sw_clean_o     (sw_clean_o[i]),
            .press_o        (press_o[i]),
            .release_o      (release_o[i]),
            .long_o         (long_o[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with DB_CYC=8, LONG_CYC=20, N_CH=4.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] clean, press, rel, lng;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .N_CH(4), .CLK_HZ(4000), .DB_MS(2), .LONG_MS(5)
    ) dut (
        .clk_50MHz_i    (clk),
        .rst_async_la_i (rst_n),
        .sw_noisy_i     (sw),
        .sw_clean_o     (clean),
        .press_o        (press),
        .release_o      (rel),
        .long_o         (lng)
    );

    // After tick(k+1) from an input change, we sit 1 ns past edge k.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    initial begin
        logic [3:0] long_exp;
`ifdef DEBOUNCE_LONG_PRESS_EN
        long_exp = 4'b1001;
`else
        long_exp = 4'b0000;
`endif
        rst_n = 1'b0;
        sw    = 4'b0000;
        tick(3);
        chk("rst_clean", clean, 4'b0000);
        chk("rst_press", press, 4'b0000);
        chk("rst_release", rel, 4'b0000);
        chk("rst_long", lng, 4'b0000);
        rst_n = 1'b1;
        tick(2);

        // clean press on ch0
        sw = 4'b0001;
        tick(10);
        chk("press_e9_clean", clean, 4'b0000);
        chk("press_e9_press", press, 4'b0000);
        tick(1);
        chk("press_e10_clean", clean, 4'b0001);
        chk("press_e10_press", press, 4'b0001);
        tick(1);
        chk("press_e11_press", press, 4'b0000);
        chk("press_e11_clean", clean, 4'b0001);

        // clean release on ch0
        sw = 4'b0000;
        tick(10);
        chk("rel_e9_clean", clean, 4'b0001);
        chk("rel_e9_release", rel, 4'b0000);
        tick(1);
        chk("rel_e10_clean", clean, 4'b0000);
        chk("rel_e10_release", rel, 4'b0001);
        tick(1);
        chk("rel_e11_release", rel, 4'b0000);

        // 5-cycle pulse on ch1 must be rejected
        sw = 4'b0010;
        tick(5);
        sw = 4'b0000;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            chk("bounce_press", press, 4'b0000);
            chk("bounce_clean", clean, 4'b0000);
        end
        // FSM back in IDLE: a fresh press debounces with nominal latency
        sw = 4'b0010;
        tick(10);
        chk("bounce_idle_e9", press, 4'b0000);
        tick(1);
        chk("bounce_idle_e10", press, 4'b0010);
        sw = 4'b0000;
        tick(14);
        chk("bounce_idle_rel", clean, 4'b0000);

        // ch2: settle, short release bounce, then real release
        sw = 4'b0100;
        tick(11);
        chk("ch2_press", press, 4'b0100);
        tick(3);
        sw = 4'b0000;
        tick(4);
        sw = 4'b0100;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            chk("ch2_bounce_clean", clean, 4'b0100);
            chk("ch2_bounce_release", rel, 4'b0000);
            chk("ch2_bounce_press", press, 4'b0000);
        end
        sw = 4'b0000;
        tick(10);
        chk("ch2_rel_e9", rel, 4'b0000);
        chk("ch2_rel_e9_clean", clean, 4'b0100);
        tick(1);
        chk("ch2_rel_e10", rel, 4'b0100);
        chk("ch2_rel_e10_clean", clean, 4'b0000);
        tick(4);

        // simultaneous ch0+ch3 press, then hold for long-press
        sw = 4'b1001;
        tick(10);
        chk("sim_e9", press, 4'b0000);
        tick(1);
        chk("sim_e10", press, 4'b1001);
        chk("sim_e10_clean", clean, 4'b1001);
        tick(1);
        chk("sim_e11", press, 4'b0000);
        tick(18);
        chk("long_e29", lng, 4'b0000);
        tick(1);
        chk("long_e30", lng, long_exp);
        for (int i = 0; i < 30; i++) begin
            tick(1);
            chk("long_once", lng, 4'b0000);
        end
        chk("long_hold_clean", clean, 4'b1001);

        // ch3 stays held; ch0 released and re-pressed, reset at cnt=5
        sw = 4'b1000;
        tick(14);
        chk("pre_rst_clean", clean, 4'b1000);
        sw = 4'b1001;
        tick(8);
        rst_n = 1'b0;
        #1;
        chk("midrst_clean", clean, 4'b0000);
        chk("midrst_press", press, 4'b0000);
        chk("midrst_release", rel, 4'b0000);
        chk("midrst_long", lng, 4'b0000);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("post_rst_e9", press, 4'b0000);
        tick(1);
        chk("post_rst_e10", press, 4'b1001);
        chk("post_rst_e10_clean", clean, 4'b1001);
        tick(1);
        chk("post_rst_e11", press, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
